// File: rtl/gpio_in.sv
// gpio_in: 8-pin memory-mapped input port with synchroniser, edge capture and sticky W1C flags.
// Optional per-pin debouncer is compiled in with `define GPIO_IN_DEBOUNCE_EN.
module gpio_in #(
   parameter logic [3:0]  BASE   = 4'h2,
   parameter logic [15:0] DB_DIV = 16'd1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] din,
   input  logic        read,
   input  logic        write,
   input  logic [5:0]  id,
   output logic [15:0] dout,
   input  logic [7:0]  pins,
   output logic        irq
);

   logic       sel;
   logic [1:0] off;
   logic       wr_pend;
   logic       wr_rise_en;
   logic       wr_fall_en;

   logic [7:0] s1_q;
   logic [7:0] s2_q;
   logic [7:0] prev_q;
   logic [7:0] stable;
   logic [7:0] pend_q, pend_d;
   logic [7:0] rise_en_q;
   logic [7:0] fall_en_q;
   logic [7:0] clr;
   logic [7:0] rise;
   logic [7:0] fall;
   logic [7:0] rd_data;

   // BASE[0] is reserved, so only BASE[3:1] takes part in the decode.
   assign sel        = id[5] && (id[4:2] == BASE[3:1]);
   assign off        = id[1:0];
   assign wr_pend    = write && sel && (off == 2'd1);
   assign wr_rise_en = write && sel && (off == 2'd2);
   assign wr_fall_en = write && sel && (off == 2'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 8'h00;
         s2_q <= 8'h00;
      end else begin
         s1_q <= pins;
         s2_q <= s1_q;
      end
   end

`ifdef GPIO_IN_DEBOUNCE_EN
   logic [15:0]     presc_q, presc_d;
   logic            tick;
   logic [7:0]      stable_q, stable_d;
   logic [7:0][1:0] agree_q, agree_d;

   always_comb begin
      tick     = (presc_q == (DB_DIV - 16'd1));
      presc_d  = tick ? 16'd0 : presc_q + 16'd1;
      stable_d = stable_q;
      agree_d  = agree_q;
      if (tick) begin
         for (int i = 0; i < 8; i++) begin
            if (s2_q[i] != stable_q[i]) begin
               // Third consecutive disagreeing tick commits the new level.
               if (agree_q[i] == 2'd2) begin
                  stable_d[i] = s2_q[i];
                  agree_d[i]  = 2'd0;
               end else begin
                  agree_d[i]  = agree_q[i] + 2'd1;
               end
            end else begin
               agree_d[i] = 2'd0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q  <= 16'd0;
         stable_q <= 8'h00;
         agree_q  <= '0;
      end else begin
         presc_q  <= presc_d;
         stable_q <= stable_d;
         agree_q  <= agree_d;
      end
   end

   assign stable = stable_q;
`else
   assign stable = s2_q;
`endif

   assign clr  = wr_pend ? din[7:0] : 8'h00;
   assign rise = stable & ~prev_q & rise_en_q;
   assign fall = ~stable & prev_q & fall_en_q;

   // Set terms are OR-ed in after the clear so a coincident edge wins.
   always_comb begin
      pend_d = (pend_q & ~clr) | rise | fall;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q    <= 8'h00;
         pend_q    <= 8'h00;
         rise_en_q <= 8'h00;
         fall_en_q <= 8'h00;
      end else begin
         prev_q <= stable;
         pend_q <= pend_d;
         if (wr_rise_en) rise_en_q <= din[7:0];
         if (wr_fall_en) fall_en_q <= din[7:0];
      end
   end

   always_comb begin
      rd_data = 8'h00;
      case (off)
         2'd0:    rd_data = stable;
         2'd1:    rd_data = pend_q;
         2'd2:    rd_data = rise_en_q;
         default: rd_data = fall_en_q;
      endcase
   end

   assign dout = (read && sel) ? {8'h00, rd_data} : 16'hzzzz;
   assign irq  = |pend_q;

   logic unused_ok;
   assign unused_ok = ^{din[15:8], DB_DIV};

endmodule

// File: tb/tb_gpio_in.sv
// Self-checking bench for gpio_in: vector table for register/edge behaviour plus
// hand sequences for latency, set-beats-clear, bus decode, strobe conflict and async reset.
module tb_gpio_in;

   localparam logic [3:0]  BASE   = 4'h2;
   localparam logic [15:0] DB_DIV = 16'd4;
`ifdef GPIO_IN_DEBOUNCE_EN
   localparam int EXTRA = 16;
`else
   localparam int EXTRA = 0;
`endif

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] din   = 16'h0000;
   logic        read  = 1'b0;
   logic        write = 1'b0;
   logic [5:0]  id    = 6'd0;
   logic [7:0]  pins  = 8'h00;
   tri1  [15:0] dout;
   logic        irq;

   int errors = 0;
   int checks = 0;

   gpio_in #(.BASE(BASE), .DB_DIV(DB_DIV)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (din),
      .read  (read),
      .write (write),
      .id    (id),
      .dout  (dout),
      .pins  (pins),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  pins;
      logic        do_wr;
      logic [1:0]  wr_off;
      logic [7:0]  wr_data;
      int          settle;
      logic [1:0]  rd_off;
      logic [15:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[15];

   function automatic logic [5:0] rid(input logic [1:0] o);
      return {1'b1, BASE[3:1], o};
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Undriven bus is pulled up on the bench side; either form means "released".
   task automatic chk_z(input string name);
      checks++;
      if (!(dout === 16'hFFFF || dout === 16'hzzzz)) begin
         errors++;
         $display("FAIL %s: got %h expected released bus", name, dout);
      end
   endtask

   task automatic chk_irq(input string name, input logic exp);
      chk(name, {15'd0, irq}, {15'd0, exp});
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [1:0] o, input logic [7:0] d);
      id    = rid(o);
      din   = {8'h00, d};
      write = 1'b1;
      @(negedge clk);
      write = 1'b0;
      din   = 16'h0000;
      id    = 6'd0;
   endtask

   task automatic rd_chk(input logic [1:0] o, input logic [15:0] exp, input string name);
      id   = rid(o);
      read = 1'b1;
      #1;
      chk(name, dout, exp);
      read = 1'b0;
      id   = 6'd0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [5:0] bad_id;
      int         lat;

      vecs[0]  = '{8'h00, 1'b0, 2'd0, 8'h00, 4, 2'd0, 16'h0000, 1'b0};
      vecs[1]  = '{8'h00, 1'b1, 2'd2, 8'h0F, 1, 2'd2, 16'h000F, 1'b0};
      vecs[2]  = '{8'h05, 1'b0, 2'd0, 8'h00, 4, 2'd1, 16'h0005, 1'b1};
      vecs[3]  = '{8'h05, 1'b1, 2'd1, 8'h01, 1, 2'd1, 16'h0004, 1'b1};
      vecs[4]  = '{8'h05, 1'b1, 2'd3, 8'h30, 1, 2'd3, 16'h0030, 1'b1};
      vecs[5]  = '{8'h35, 1'b0, 2'd0, 8'h00, 4, 2'd1, 16'h0004, 1'b1};
      vecs[6]  = '{8'h05, 1'b0, 2'd0, 8'h00, 4, 2'd1, 16'h0034, 1'b1};
      vecs[7]  = '{8'h05, 1'b1, 2'd1, 8'hFF, 1, 2'd1, 16'h0000, 1'b0};
      vecs[8]  = '{8'h0A, 1'b0, 2'd0, 8'h00, 4, 2'd1, 16'h000A, 1'b1};
      vecs[9]  = '{8'h0A, 1'b0, 2'd0, 8'h00, 0, 2'd0, 16'h000A, 1'b1};
      vecs[10] = '{8'h0A, 1'b1, 2'd0, 8'h55, 1, 2'd0, 16'h000A, 1'b1};
      vecs[11] = '{8'h0A, 1'b1, 2'd1, 8'h02, 1, 2'd1, 16'h0008, 1'b1};
      vecs[12] = '{8'h0A, 1'b1, 2'd1, 8'h08, 1, 2'd1, 16'h0000, 1'b0};
      vecs[13] = '{8'h0A, 1'b1, 2'd2, 8'h00, 1, 2'd2, 16'h0000, 1'b0};
      vecs[14] = '{8'h0A, 1'b1, 2'd3, 8'h00, 1, 2'd3, 16'h0000, 1'b0};

      // Reset with pins already high: DATA follows, no flag appears.
      pins  = 8'hFF;
      rst_n = 1'b0;
      cyc(3);
      rst_n = 1'b1;
      cyc(10 + EXTRA);
      chk_z("rst_dout_idle");
      chk_irq("rst_irq", 1'b0);
      rd_chk(2'd0, 16'h00FF, "rst_data");
      rd_chk(2'd1, 16'h0000, "rst_pend");
      rd_chk(2'd2, 16'h0000, "rst_rise_en");

      for (int i = 0; i < 15; i++) begin
         pins = vecs[i].pins;
         if (vecs[i].do_wr) bus_write(vecs[i].wr_off, vecs[i].wr_data);
         cyc(vecs[i].settle + EXTRA);
         rd_chk(vecs[i].rd_off, vecs[i].exp_rd, $sformatf("vec%0d_rd", i));
         chk_irq($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
      end

`ifndef GPIO_IN_DEBOUNCE_EN
      // Exact latency of a rising edge, then W1C drops irq on the next edge.
      pins = 8'h00;
      cyc(4);
      bus_write(2'd2, 8'h01);
      pins = 8'h01;
      cyc(1);
      chk_irq("lat_irq_k", 1'b0);
      cyc(1);
      rd_chk(2'd0, 16'h0001, "lat_data_k1");
      chk_irq("lat_irq_k1", 1'b0);
      cyc(1);
      chk_irq("lat_irq_k2", 1'b1);
      rd_chk(2'd1, 16'h0001, "lat_pend");
      id    = rid(2'd1);
      din   = 16'h0001;
      write = 1'b1;
      #1;
      chk_irq("clr_irq_before", 1'b1);
      @(negedge clk);
      write = 1'b0;
      id    = 6'd0;
      chk_irq("clr_irq_after", 1'b0);
`endif

      // Falling edge with only pin 7 enabled.
      bus_write(2'd2, 8'h00);
      bus_write(2'd3, 8'h80);
      pins = 8'hFF;
      cyc(4 + EXTRA);
      rd_chk(2'd1, 16'h0000, "fall_pre");
      pins = 8'h00;
      cyc(4 + EXTRA);
      rd_chk(2'd1, 16'h0080, "fall_mask");
      chk_irq("fall_irq", 1'b1);
      bus_write(2'd1, 8'hFF);

`ifndef GPIO_IN_DEBOUNCE_EN
      // A W1C landing on the same edge as a new rising edge loses.
      bus_write(2'd2, 8'h04);
      pins = 8'h04;
      cyc(4);
      rd_chk(2'd1, 16'h0004, "sbc_pre");
      pins = 8'h00;
      cyc(4);
      pins = 8'h04;
      cyc(2);
      id    = rid(2'd1);
      din   = 16'h0004;
      write = 1'b1;
      @(negedge clk);
      write = 1'b0;
      id    = 6'd0;
      rd_chk(2'd1, 16'h0004, "set_beats_clr");
      bus_write(2'd1, 8'h04);
      rd_chk(2'd1, 16'h0000, "clr_alone");
`endif

      // Bus decode: unselected ids neither drive dout nor write.
      bus_write(2'd2, 8'h5A);
      bad_id = {1'b1, BASE[3:1] ^ 3'b010, 2'd2};
      id   = {1'b0, BASE[3:1], 2'd2};
      read = 1'b1;
      #1;
      chk_z("idle_id5");
      id = bad_id;
      #1;
      chk_z("idle_base");
      read = 1'b0;
      id   = rid(2'd2);
      #1;
      chk_z("idle_noread");
      @(negedge clk);
      id    = {1'b0, BASE[3:1], 2'd2};
      din   = 16'h00FF;
      write = 1'b1;
      @(negedge clk);
      id = bad_id;
      @(negedge clk);
      write = 1'b0;
      id    = 6'd0;
      rd_chk(2'd2, 16'h005A, "nosel_write");

      // Read and write together: read shows the pre-write value.
      id    = rid(2'd2);
      din   = 16'h00C3;
      read  = 1'b1;
      write = 1'b1;
      #1;
      chk("conflict_pre", dout, 16'h005A);
      @(negedge clk);
      read  = 1'b0;
      write = 1'b0;
      id    = 6'd0;
      rd_chk(2'd2, 16'h00C3, "conflict_post");

      // Asynchronous reset between clock edges.
      bus_write(2'd2, 8'hFF);
      pins = 8'hFF;
      cyc(4 + EXTRA);
      chk_irq("pre_rst_irq", 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_irq("async_irq", 1'b0);
      rd_chk(2'd2, 16'h0000, "async_en");
      @(negedge clk);
      rst_n = 1'b1;
      cyc(10 + EXTRA);
      rd_chk(2'd0, 16'h00FF, "rerst_data");
      rd_chk(2'd1, 16'h0000, "rerst_pend");

`ifdef GPIO_IN_DEBOUNCE_EN
      // Short glitch is rejected, held level is accepted within the tick budget.
      bus_write(2'd2, 8'h08);
      pins = 8'hF7;
      cyc(30);
      rd_chk(2'd0, 16'h00F7, "db_base");
      bus_write(2'd1, 8'hFF);
      pins = 8'hFF;
      cyc(6);
      pins = 8'hF7;
      cyc(30);
      rd_chk(2'd0, 16'h00F7, "db_glitch_data");
      rd_chk(2'd1, 16'h0000, "db_glitch_pend");
      pins = 8'hFF;
      lat  = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         id   = rid(2'd0);
         read = 1'b1;
         #1;
         if (dout === 16'h00FF && lat == 0) lat = c;
         read = 1'b0;
         id   = 6'd0;
      end
      checks++;
      if (lat == 0 || lat > 16) begin
         errors++;
         $display("FAIL db_hold: DATA updated after %0d cycles, required 1..16", lat);
      end
      rd_chk(2'd1, 16'h0008, "db_hold_pend");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
